// File: rtl/imsic_pkg.sv
// Shared encodings for the IMSIC CSR channel initiator: request kinds,
// write ops, interrupt-file register addresses and the initiator FSM states.
package imsic_pkg;

  localparam logic [1:0] KIND_IREG_RD     = 2'b00;
  localparam logic [1:0] KIND_IREG_WR     = 2'b01;
  localparam logic [1:0] KIND_TOPEI_RD    = 2'b10;
  localparam logic [1:0] KIND_TOPEI_CLAIM = 2'b11;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [11:0] ADDR_EIDELIVERY  = 12'h070;
  localparam logic [11:0] ADDR_EITHRESHOLD = 12'h072;
  localparam logic [11:0] ADDR_EIP0        = 12'h080;
  localparam logic [11:0] ADDR_EIE0        = 12'h0C0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // ireg accesses (kinds 00/01) are the ones steered by iselect
  function automatic logic is_ireg(input logic [1:0] kind);
    return ~kind[1];
  endfunction

endpackage

// File: rtl/imsic_csr_initiator_if.sv
// Bundle of the hart request/response handshake and the channel toward
// imsic_csr_reg. Handshake rules: a request transfers on a clock edge where
// req_vld and req_rdy are both high; req_rdy is high only while idle; rsp_vld
// is a one-cycle pulse with no back-pressure; csr_rd is a one-cycle strobe and
// the channel answers with csr_rdata_vld (csr_illegal/csr_rdata valid with it).
// The master modport is the initiator's view, slave is the hart+channel view.
interface imsic_csr_initiator_if #(
  parameter int XLEN            = 64,
  parameter int INTP_FILE_WIDTH = 3
);
  logic                       req_vld;
  logic                       req_rdy;
  logic [1:0]                 req_kind;
  logic [11:0]                req_iselect;
  logic [1:0]                 req_op;
  logic [XLEN-1:0]            req_wdata;
  logic [INTP_FILE_WIDTH-1:0] req_file;
  logic                       req_v;
  logic                       rsp_vld;
  logic [XLEN-1:0]            rsp_rdata;
  logic                       rsp_illegal;
  logic [11:0]                csr_addr;
  logic                       csr_rd;
  logic [INTP_FILE_WIDTH-1:0] intp_file_sel;
  logic                       csr_wdata_vld;
  logic                       csr_v;
  logic [XLEN-1:0]            csr_wdata;
  logic [1:0]                 csr_wdata_op;
  logic                       csr_rdata_vld;
  logic [XLEN-1:0]            csr_rdata;
  logic                       csr_illegal;

  modport master (
    input  req_vld, req_kind, req_iselect, req_op, req_wdata, req_file, req_v,
    input  csr_rdata_vld, csr_rdata, csr_illegal,
    output req_rdy, rsp_vld, rsp_rdata, rsp_illegal,
    output csr_addr, csr_rd, intp_file_sel, csr_wdata_vld, csr_v, csr_wdata, csr_wdata_op
  );

  modport slave (
    output req_vld, req_kind, req_iselect, req_op, req_wdata, req_file, req_v,
    output csr_rdata_vld, csr_rdata, csr_illegal,
    input  req_rdy, rsp_vld, rsp_rdata, rsp_illegal,
    input  csr_addr, csr_rd, intp_file_sel, csr_wdata_vld, csr_v, csr_wdata, csr_wdata_op
  );
endinterface

// File: rtl/imsic_claim_addr.sv
// Maps a topei identity to the eip register holding its pending bit and the
// one-hot mask of that bit. On RV64 only even eip registers exist, so the
// register index is doubled.
module imsic_claim_addr
  import imsic_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [10:0]     id,
  output logic [11:0]     addr,
  output logic [XLEN-1:0] mask
);
  localparam int SHIFT = $clog2(XLEN);

  logic [11:0] idx;
  logic [11:0] step;

  // register index and bit position from the identity
  always_comb begin
    idx  = {1'b0, id >> SHIFT};
    step = (XLEN == 64) ? (idx << 1) : idx;
    addr = ADDR_EIP0 + step;
    mask = XLEN'(1) << id[SHIFT-1:0];
  end
endmodule

// File: rtl/imsic_csr_initiator.sv
// Hart-side initiator: turns one indirect-CSR request into at most one
// single-cycle channel access and returns a one-cycle response.
module imsic_csr_initiator
  import imsic_pkg::*;
#(
  parameter int NR_INTP_FILES   = 7,
  parameter int XLEN            = 64,
  parameter int NR_SRC_WIDTH    = 8,
  parameter int INTP_FILE_WIDTH = 3,
  parameter int TIMEOUT         = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  imsic_csr_initiator_if.master         bus,
  input  logic [NR_INTP_FILES-1:0][31:0] xtopei,
  output state_t                        dbg_state
);
  state_t          state_q, state_d;
  logic [1:0]      kind_q;
  logic [31:0]     topei_q;
  logic [3:0]      wait_cnt_q;
  logic [31:0]     topei_live;
  logic [11:0]     claim_addr;
  logic [XLEN-1:0] claim_mask;
  logic            wait_done;
  logic            issue_start;
  logic [XLEN-1:0] rsp_rdata_d;
  logic            rsp_illegal_d;
  logic [11:0]     csr_addr_d;
  logic            csr_wdata_vld_d;
  logic [1:0]      csr_op_d;
  logic [XLEN-1:0] csr_wdata_d;

  // an out-of-range file select reads as an empty topei
  assign topei_live  = (32'(bus.req_file) < NR_INTP_FILES) ? xtopei[bus.req_file] : '0;
  assign wait_done   = (wait_cnt_q == 4'(TIMEOUT - 1));
  assign issue_start = (state_q == ST_IDLE) && (state_d == ST_ISSUE);
  assign dbg_state   = state_q;

  imsic_claim_addr #(.XLEN(XLEN)) u_claim_addr (
    .id   (topei_live[26:16]),
    .addr (claim_addr),
    .mask (claim_mask)
  );

  // next state plus the response payload that goes with entering RESP
  always_comb begin
    state_d       = state_q;
    rsp_rdata_d   = '0;
    rsp_illegal_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_vld) begin
          if (is_ireg(bus.req_kind) && (bus.req_iselect[11:8] != 4'h0)) begin
            state_d       = ST_RESP;
            rsp_illegal_d = 1'b1;
          end else if (bus.req_kind == KIND_TOPEI_RD) begin
            state_d     = ST_RESP;
            rsp_rdata_d = XLEN'(topei_live);
          end else if ((bus.req_kind == KIND_TOPEI_CLAIM) && (topei_live[26:16] == 11'd0)) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // a reply on the terminal-count cycle still counts as a normal reply
        if (bus.csr_rdata_vld) begin
          state_d       = ST_RESP;
          rsp_rdata_d   = (kind_q == KIND_TOPEI_CLAIM) ? XLEN'(topei_q) : bus.csr_rdata;
          rsp_illegal_d = bus.csr_illegal;
        end else if (wait_done) begin
          state_d       = ST_RESP;
          rsp_illegal_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // channel access fields derived from the request being accepted
  always_comb begin
    csr_addr_d      = bus.req_iselect;
    csr_wdata_vld_d = 1'b0;
    csr_op_d        = OP_NONE;
    csr_wdata_d     = '0;
    if (bus.req_kind == KIND_IREG_WR) begin
      csr_wdata_vld_d = 1'b1;
      csr_op_d        = bus.req_op;
      csr_wdata_d     = bus.req_wdata;
    end else if (bus.req_kind == KIND_TOPEI_CLAIM) begin
      csr_addr_d      = claim_addr;
      csr_wdata_vld_d = 1'b1;
      csr_op_d        = OP_CLR;
      csr_wdata_d     = claim_mask;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // request latch and saturating WAIT counter, cleared on entry to WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q     <= KIND_IREG_RD;
      topei_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && bus.req_vld) begin
        kind_q  <= bus.req_kind;
        topei_q <= bus.req_kind[1] ? topei_live : 32'd0;
      end
      if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) wait_cnt_q <= '0;
      else if ((state_q == ST_WAIT) && (wait_cnt_q != 4'hF)) wait_cnt_q <= wait_cnt_q + 4'd1;
    end
  end

  // registered outputs; channel fields are non-zero only in the ISSUE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.req_rdy       <= 1'b1;
      bus.rsp_vld       <= 1'b0;
      bus.rsp_rdata     <= '0;
      bus.rsp_illegal   <= 1'b0;
      bus.csr_rd        <= 1'b0;
      bus.csr_addr      <= '0;
      bus.intp_file_sel <= '0;
      bus.csr_wdata_vld <= 1'b0;
      bus.csr_v         <= 1'b0;
      bus.csr_wdata     <= '0;
      bus.csr_wdata_op  <= OP_NONE;
    end else begin
      bus.req_rdy       <= (state_d == ST_IDLE);
      bus.rsp_vld       <= (state_d == ST_RESP);
      bus.rsp_rdata     <= rsp_rdata_d;
      bus.rsp_illegal   <= rsp_illegal_d;
      bus.csr_rd        <= issue_start;
      bus.csr_addr      <= issue_start ? csr_addr_d : 12'd0;
      bus.intp_file_sel <= issue_start ? bus.req_file : '0;
      bus.csr_wdata_vld <= issue_start & csr_wdata_vld_d;
      bus.csr_v         <= issue_start & bus.req_v;
      bus.csr_wdata     <= issue_start ? csr_wdata_d : '0;
      bus.csr_wdata_op  <= issue_start ? csr_op_d : OP_NONE;
    end
  end
endmodule

// File: tb/tb_imsic_csr_initiator.sv
// Directed bench for imsic_csr_initiator: a table of request vectors with a
// scripted channel reply, plus hand sequences for reset, stray replies and
// reset during WAIT.
module tb_imsic_csr_initiator;
  import imsic_pkg::*;

  localparam int XLEN = 64;
  localparam int NR   = 7;
  localparam int FW   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0][31:0] xtopei;
  state_t            dbg_state;

  imsic_csr_initiator_if #(.XLEN(XLEN), .INTP_FILE_WIDTH(FW)) bus ();

  imsic_csr_initiator #(
    .NR_INTP_FILES(NR), .XLEN(XLEN), .NR_SRC_WIDTH(8), .INTP_FILE_WIDTH(FW), .TIMEOUT(15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .xtopei    (xtopei),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic [1:0]  kind;
    logic [11:0] isel;
    logic [1:0]  op;
    logic [63:0] wdata;
    logic [2:0]  file;
    logic        v;
    logic [31:0] topei;
    int          lat;    // reply cycle offset after ISSUE, 0 = silent channel
    int          stray;  // cycle of an early bogus reply, 0 = none
    logic [63:0] cdata;
    logic        cill;
    logic        exp_issue;
    logic [11:0] exp_addr;
    logic        exp_wvld;
    logic [1:0]  exp_op;
    logic [63:0] exp_wdata;
    int          exp_cyc;
    logic [63:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chan_idle();
    bus.csr_rdata_vld = 1'b0;
    bus.csr_rdata     = '0;
    bus.csr_illegal   = 1'b0;
  endtask

  // driver: present one request, script the channel, check every cycle
  task automatic run_vec(input int n, input vec_t t);
    int cyc;
    bit rsp_seen;
    int issues;
    bit clean;
    xtopei            = '0;
    xtopei[t.file]    = t.topei;
    bus.req_kind      = t.kind;
    bus.req_iselect   = t.isel;
    bus.req_op        = t.op;
    bus.req_wdata     = t.wdata;
    bus.req_file      = t.file;
    bus.req_v         = t.v;
    bus.req_vld       = 1'b1;
    exp_q.push_back(t.exp_rdata);
    tick();
    bus.req_vld = 1'b0;
    cyc = 1; rsp_seen = 0; issues = 0; clean = 1;
    check($sformatf("v%0d_rdy_busy", n), 64'(bus.req_rdy), 64'd0);
    while (!rsp_seen && cyc <= 40) begin
      if (bus.csr_rd) begin
        issues++;
        check($sformatf("v%0d_issue_cyc", n), 64'(cyc), 64'd1);
        check($sformatf("v%0d_addr", n), 64'(bus.csr_addr), 64'(t.exp_addr));
        check($sformatf("v%0d_wvld", n), 64'(bus.csr_wdata_vld), 64'(t.exp_wvld));
        check($sformatf("v%0d_op", n), 64'(bus.csr_wdata_op), 64'(t.exp_op));
        check($sformatf("v%0d_wdata", n), bus.csr_wdata, t.exp_wdata);
        check($sformatf("v%0d_file", n), 64'(bus.intp_file_sel), 64'(t.file));
        check($sformatf("v%0d_virt", n), 64'(bus.csr_v), 64'(t.v));
      end else if (bus.csr_addr != 0 || bus.csr_wdata_vld || bus.csr_wdata != 0 ||
                   bus.csr_wdata_op != 0 || bus.intp_file_sel != 0 || bus.csr_v) begin
        clean = 0;
      end
      if (bus.rsp_vld) begin
        rsp_seen = 1;
        check($sformatf("v%0d_rsp_cyc", n), 64'(cyc), 64'(t.exp_cyc));
        check($sformatf("v%0d_rdata", n), bus.rsp_rdata, exp_q.pop_front());
        check($sformatf("v%0d_illegal", n), 64'(bus.rsp_illegal), 64'(t.exp_ill));
      end
      chan_idle();
      if (t.lat != 0 && cyc == 1 + t.lat) begin
        bus.csr_rdata_vld = 1'b1;
        bus.csr_rdata     = t.cdata;
        bus.csr_illegal   = t.cill;
      end else if (t.stray != 0 && cyc == t.stray) begin
        bus.csr_rdata_vld = 1'b1;
        bus.csr_rdata     = 64'hBAD;
        bus.csr_illegal   = 1'b1;
      end
      tick();
      cyc++;
    end
    chan_idle();
    if (!rsp_seen) begin
      check($sformatf("v%0d_rsp_timeout", n), 64'd0, 64'd1);
      exp_q.delete();
    end
    check($sformatf("v%0d_issue_count", n), 64'(issues), 64'(t.exp_issue));
    check($sformatf("v%0d_quiet_outside_issue", n), 64'(clean), 64'd1);
    check($sformatf("v%0d_rsp_pulse", n), 64'(bus.rsp_vld), 64'd0);
    check($sformatf("v%0d_rdy_after", n), 64'(bus.req_rdy), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit quiet;
    //          kind   isel     op     wdata   file v  topei          lat st cdata   cill iss addr    wvld op     wdata        cyc rdata          ill
    vecs[0]  = '{2'b00, 12'h072, 2'b00, 64'h0,  3'd1, 0, 32'h0,         1, 0, 64'h5,    0, 1, 12'h072, 0, 2'b00, 64'h0,               3, 64'h5,          0};
    vecs[1]  = '{2'b01, 12'h0C0, 2'b10, 64'hF0, 3'd2, 1, 32'h0,         1, 0, 64'h1234, 0, 1, 12'h0C0, 1, 2'b10, 64'hF0,              3, 64'h1234,       0};
    vecs[2]  = '{2'b11, 12'h000, 2'b00, 64'h0,  3'd0, 0, 32'h00460046,  1, 0, 64'hDEAD, 0, 1, 12'h082, 1, 2'b11, 64'h40,              3, 64'h00460046,   0};
    vecs[3]  = '{2'b11, 12'h000, 2'b00, 64'h0,  3'd0, 0, 32'h00000005,  1, 0, 64'h0,    0, 0, 12'h000, 0, 2'b00, 64'h0,               1, 64'h0,          0};
    vecs[4]  = '{2'b00, 12'h170, 2'b00, 64'h0,  3'd1, 0, 32'h0,         1, 0, 64'h0,    0, 0, 12'h000, 0, 2'b00, 64'h0,               1, 64'h0,          1};
    vecs[5]  = '{2'b10, 12'h000, 2'b00, 64'h0,  3'd3, 0, 32'h00230023,  1, 0, 64'h0,    0, 0, 12'h000, 0, 2'b00, 64'h0,               1, 64'h00230023,   0};
    vecs[6]  = '{2'b00, 12'h030, 2'b00, 64'h0,  3'd5, 1, 32'h0,         1, 0, 64'h77,   1, 1, 12'h030, 0, 2'b00, 64'h0,               3, 64'h77,         1};
    vecs[7]  = '{2'b00, 12'h070, 2'b00, 64'h0,  3'd1, 0, 32'h0,         0, 0, 64'h0,    0, 1, 12'h070, 0, 2'b00, 64'h0,              17, 64'h0,          1};
    vecs[8]  = '{2'b00, 12'h070, 2'b00, 64'h0,  3'd1, 0, 32'h0,        15, 0, 64'h99,   0, 1, 12'h070, 0, 2'b00, 64'h0,              17, 64'h99,         0};
    vecs[9]  = '{2'b00, 12'h070, 2'b00, 64'h0,  3'd4, 0, 32'h0,         3, 0, 64'h33,   0, 1, 12'h070, 0, 2'b00, 64'h0,               5, 64'h33,         0};
    vecs[10] = '{2'b11, 12'h000, 2'b00, 64'h0,  3'd6, 1, 32'h07FF0001,  1, 0, 64'h0,    0, 1, 12'h0BE, 1, 2'b11, 64'h8000000000000000, 3, 64'h07FF0001,   0};
    vecs[11] = '{2'b00, 12'h070, 2'b00, 64'h0,  3'd4, 0, 32'h0,         2, 1, 64'h22,   0, 1, 12'h070, 0, 2'b00, 64'h0,               4, 64'h22,         0};

    rst = 1'b1;
    xtopei = '0;
    bus.req_vld = 1'b0; bus.req_kind = '0; bus.req_iselect = '0; bus.req_op = '0;
    bus.req_wdata = '0; bus.req_file = '0; bus.req_v = 1'b0;
    chan_idle();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    check("reset_rdy", 64'(bus.req_rdy), 64'd1);
    check("reset_rsp_vld", 64'(bus.rsp_vld), 64'd0);
    check("reset_csr_rd", 64'(bus.csr_rd), 64'd0);
    check("reset_csr_addr", 64'(bus.csr_addr), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));

    // table-driven vectors
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // kind 01 with op 00 is forwarded unchanged
    run_vec(12, '{2'b01, 12'h080, 2'b00, 64'h3, 3'd2, 0, 32'h0, 1, 0, 64'h0, 0,
                  1, 12'h080, 1, 2'b00, 64'h3, 3, 64'h0, 0});

    // stray channel replies while idle produce nothing
    quiet = 1;
    bus.csr_rdata_vld = 1'b1; bus.csr_rdata = 64'hABC; bus.csr_illegal = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.rsp_vld || !bus.req_rdy || bus.csr_rd) quiet = 0;
    end
    chan_idle();
    tick();
    check("idle_stray_ignored", 64'(quiet), 64'd1);
    check("idle_stray_rsp", 64'(bus.rsp_vld), 64'd0);

    // reset during WAIT drops the request
    bus.req_kind = KIND_IREG_RD; bus.req_iselect = 12'h072; bus.req_file = 3'd1;
    bus.req_v = 1'b0; bus.req_vld = 1'b1;
    tick();                        // cycle 1: ISSUE
    bus.req_vld = 1'b0;
    check("rstwait_issue", 64'(bus.csr_rd), 64'd1);
    tick();                        // cycle 2: WAIT
    tick();                        // cycle 3: WAIT
    check("rstwait_in_wait", 64'(dbg_state), 64'(ST_WAIT));
    rst = 1'b1;
    tick();                        // cycle 4
    rst = 1'b0;
    quiet = 1;
    if (bus.rsp_vld) quiet = 0;
    tick();                        // cycle 5
    check("rstwait_rdy_after_release", 64'(bus.req_rdy), 64'd1);
    check("rstwait_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    bus.csr_rdata_vld = 1'b1; bus.csr_rdata = 64'h5;   // late reply to the dropped access
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_vld || bus.csr_rd) quiet = 0;
      tick();
      chan_idle();
    end
    check("rstwait_no_rsp", 64'(quiet), 64'd1);

    // recovery: a normal access works after the mid-operation reset
    run_vec(13, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
